// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - multi-cycle byte-serial Y86-64 instruction fetcher
`ifndef DATA_WID
`define DATA_WID 64
`endif

module instr_fetch_seq #(
  parameter int ADDR_WID = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_valid,
  input  logic [ADDR_WID-1:0]  pc_in,
  output logic                 pc_ready,
  output logic                 mem_req,
  output logic [ADDR_WID-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           icode,
  output logic [3:0]           ifun,
  output logic [3:0]           rA,
  output logic [3:0]           rB,
  output logic [`DATA_WID-1:0] valC,
  output logic [ADDR_WID-1:0]  valP,
  output logic                 instr_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] IC_HALT = 4'h0;
  localparam logic [3:0] NO_REG  = 4'hF;

  // Instruction length in bytes, shared with the PC incrementer's table.
  function automatic logic [3:0] f_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       f_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
      4'h7, 4'h8:             f_len = 4'd9;
      4'h3, 4'h4, 4'h5:       f_len = 4'd10;
      default:                f_len = 4'd1;
    endcase
  endfunction

  state_t                r_state;
  logic                  r_pc_ready;
  logic                  r_mem_req;
  logic [ADDR_WID-1:0]   r_mem_addr;
  logic                  r_out_valid;
  logic [ADDR_WID-1:0]   r_pc;
  logic [3:0]            r_k;
  logic [3:0]            r_len;
  logic [3:0]            r_icode;
  logic [3:0]            r_ifun;
  logic [3:0]            r_ra;
  logic [3:0]            r_rb;
  logic [`DATA_WID-1:0]  r_valc;
  logic [ADDR_WID-1:0]   r_valp;
  logic                  r_instr_err;

  logic [3:0]            w_len_b0;
  logic [3:0]            w_len;
  logic                  w_last;
  logic                  w_regs_byte;
  logic                  w_c_byte;
  logic [3:0]            w_c_base;
  logic [2:0]            w_c_idx;
  logic [ADDR_WID-1:0]   w_next_addr;
  logic [ADDR_WID-1:0]   w_valp;

  // Byte 0 defines the length; later bytes use the latched length.
  assign w_len_b0    = f_len(mem_rdata[7:4]);
  assign w_len       = (r_k == 4'd0) ? w_len_b0 : r_len;
  assign w_last      = ((r_k + 4'd1) == w_len);
  assign w_regs_byte = (r_k == 4'd1) && ((r_len == 4'd2) || (r_len == 4'd10));
  assign w_c_byte    = ((r_len == 4'd10) && (r_k >= 4'd2)) ||
                       ((r_len == 4'd9)  && (r_k >= 4'd1));
  assign w_c_base    = (r_len == 4'd10) ? 4'd2 : 4'd1;
  assign w_c_idx     = 3'(r_k - w_c_base);
  assign w_next_addr = r_pc + ADDR_WID'(r_k + 4'd1);
  // HALT and invalid opcodes keep the PC where it is.
  assign w_valp      = ((r_icode == IC_HALT) || r_instr_err) ? r_pc
                                                            : r_pc + ADDR_WID'(r_len);

  assign pc_ready  = r_pc_ready;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign icode     = r_icode;
  assign ifun      = r_ifun;
  assign rA        = r_ra;
  assign rB        = r_rb;
  assign valC      = r_valc;
  assign valP      = r_valp;
  assign instr_err = r_instr_err;

  // Fetch FSM: accept PC, read bytes one per ack, present fields until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_k         <= 4'd0;
      r_len       <= 4'd0;
      r_icode     <= 4'h0;
      r_ifun      <= 4'h0;
      r_ra        <= NO_REG;
      r_rb        <= NO_REG;
      r_valc      <= '0;
      r_valp      <= '0;
      r_instr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pc_valid && r_pc_ready) begin
            r_pc        <= pc_in;
            r_mem_addr  <= pc_in;
            r_mem_req   <= 1'b1;
            r_pc_ready  <= 1'b0;
            r_k         <= 4'd0;
            r_len       <= 4'd0;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= NO_REG;
            r_rb        <= NO_REG;
            r_valc      <= '0;
            r_valp      <= '0;
            r_instr_err <= 1'b0;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!r_mem_req) begin
            // All bytes in: one settle cycle to form valP, then present.
            r_valp      <= w_valp;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (mem_ack) begin
            r_k <= r_k + 4'd1;
            if (r_k == 4'd0) begin
              r_icode     <= mem_rdata[7:4];
              r_ifun      <= mem_rdata[3:0];
              r_len       <= w_len_b0;
              r_instr_err <= (mem_rdata[7:4] > 4'hB);
            end else if (w_regs_byte) begin
              r_ra <= mem_rdata[7:4];
              r_rb <= mem_rdata[3:0];
            end else if (w_c_byte) begin
              r_valc[8*w_c_idx +: 8] <= mem_rdata;
            end
            if (w_last) begin
              r_mem_req <= 1'b0;
            end else begin
              r_mem_addr <= w_next_addr;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pc_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb/tb_instr_fetch_seq.sv - randomized self-checking bench for instr_fetch_seq
`timescale 1ns/1ps

module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [63:0] pc_in;
  logic        pc_ready;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_err;

  instr_fetch_seq #(.ADDR_WID(64)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .instr_err(instr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory image seen by the DUT, relative to base
  logic [7:0]  prog [16];
  logic [63:0] base;
  int          stall_off  = 0;
  int          stall_left = 0;
  int          stalls     = 0;
  int          addr_bad   = 0;
  bit          rand_ack   = 1'b0;
  logic [63:0] acked [$];
  logic [63:0] off;

  // expected results from the reference model
  int          e_len;
  logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
  logic [63:0] e_valc, e_valp;
  logic        e_err;

  // Byte-wide memory responder; acks while idle too, which the DUT must ignore.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        off = mem_addr - base;
        if (mem_addr !== base + 64'(acked.size())) addr_bad++;
        if (stall_left > 0 && off == 64'(stall_off)) begin
          mem_ack = 1'b0;
          stall_left--;
          stalls++;
        end else if (rand_ack && $urandom_range(0, 2) == 0) begin
          mem_ack = 1'b0;
          stalls++;
        end else begin
          mem_ack   = 1'b1;
          mem_rdata = (off < 64'd16) ? prog[off[3:0]] : 8'h00;
          acked.push_back(mem_addr);
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Reference model: instruction fields straight from the Y86-64 encoding rules.
  task automatic calc(input logic [63:0] pc);
    int cstart;
    e_icode = prog[0][7:4];
    e_ifun  = prog[0][3:0];
    e_err   = 1'b0;
    cstart  = -1;
    e_ra    = 4'hF;
    e_rb    = 4'hF;
    e_valc  = 64'd0;
    case (e_icode)
      4'h0, 4'h1, 4'h9:       e_len = 1;
      4'h2, 4'h6, 4'hA, 4'hB: e_len = 2;
      4'h7, 4'h8:             begin e_len = 9;  cstart = 1; end
      4'h3, 4'h4, 4'h5:       begin e_len = 10; cstart = 2; end
      default:                begin e_len = 1;  e_err = 1'b1; end
    endcase
    if (e_len == 2 || e_len == 10) begin
      e_ra = prog[1][7:4];
      e_rb = prog[1][3:0];
    end
    if (cstart >= 0)
      for (int i = 0; i < 8; i++) e_valc = e_valc | (64'(prog[cstart + i]) << (8 * i));
    e_valp = (e_icode == 4'h0 || e_err) ? pc : pc + 64'(e_len);
  endtask

  // Drive one fetch at pc, hold out_ready low for ready_delay cycles, check everything.
  task automatic run_fetch(input logic [63:0] pc, input int ready_delay, input string tag);
    int guard;
    int cyc;
    int exp_lat;
    calc(pc);
    base     = pc;
    stalls   = 0;
    addr_bad = 0;
    acked.delete();
    guard = 0;
    while (pc_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (pc_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s pc_ready_wait: got %b want 1", tag, pc_ready);
    end
    pc_valid = 1'b1;
    pc_in    = pc;
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    pc_in    = {$urandom, $urandom};
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && cyc < 200);
    exp_lat = e_len + 1 + stalls;
    total++;
    if (cyc !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, cyc, exp_lat);
    end
    total++;
    if (icode !== e_icode || ifun !== e_ifun) begin
      bad++;
      $display("FAIL %s icode_ifun: got %h%h want %h%h", tag, icode, ifun, e_icode, e_ifun);
    end
    total++;
    if (rA !== e_ra || rB !== e_rb) begin
      bad++;
      $display("FAIL %s regs: got %h%h want %h%h", tag, rA, rB, e_ra, e_rb);
    end
    total++;
    if (valC !== e_valc) begin
      bad++;
      $display("FAIL %s valC: got %h want %h", tag, valC, e_valc);
    end
    total++;
    if (valP !== e_valp) begin
      bad++;
      $display("FAIL %s valP: got %h want %h", tag, valP, e_valp);
    end
    total++;
    if (instr_err !== e_err) begin
      bad++;
      $display("FAIL %s instr_err: got %b want %b", tag, instr_err, e_err);
    end
    total++;
    if (acked.size() != e_len || addr_bad != 0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL %s bytes: got n=%0d addr_bad=%0d req=%b want n=%0d addr_bad=0 req=0",
               tag, acked.size(), addr_bad, mem_req, e_len);
    end
    for (int d = 0; d < ready_delay; d++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || pc_ready !== 1'b0 || icode !== e_icode || rA !== e_ra ||
          rB !== e_rb || valC !== e_valc || valP !== e_valp || instr_err !== e_err) begin
        bad++;
        $display("FAIL %s hold: got ov=%b pr=%b ic=%h valP=%h want ov=1 pr=0 ic=%h valP=%h",
                 tag, out_valid, pc_ready, icode, valP, e_icode, e_valp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || pc_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s handoff: got ov=%b pr=%b want ov=0 pr=1", tag, out_valid, pc_ready);
    end
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] c, input int cstart);
    for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
    prog[0] = b0;
    prog[1] = b1;
    if (cstart >= 0)
      for (int i = 0; i < 8; i++) prog[cstart + i] = c[8*i +: 8];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (pc_ready !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0 || instr_err !== 1'b0 ||
        icode !== 4'h0 || ifun !== 4'h0 || rA !== 4'hF || rB !== 4'hF ||
        valC !== 64'd0 || valP !== 64'd0 || mem_addr !== 64'd0) begin
      bad++;
      $display("FAIL reset_state: got pr=%b req=%b ov=%b rA=%h valP=%h addr=%h", pc_ready,
               mem_req, out_valid, rA, valP, mem_addr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (pc_ready !== 1'b1 || mem_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got pr=%b req=%b ov=%b want 1 0 0", pc_ready, mem_req, out_valid);
    end
  endtask

  task automatic test_nop;
    load(8'h10, 8'h00, 64'd0, -1);
    run_fetch(64'h100, 0, "nop");
  endtask

  task automatic test_irmov;
    load(8'h30, 8'hF3, 64'h0102030405060708, 2);
    run_fetch(64'h200, 1, "irmov");
  endtask

  task automatic test_call_stall;
    load(8'h80, 8'h00, 64'h100, 1);
    stall_off  = 4;
    stall_left = 3;
    run_fetch(64'h40, 0, "call_stall");
    total++;
    if (stall_left != 0) begin
      bad++;
      $display("FAIL call_stall_used: got left=%0d want 0", stall_left);
    end
    stall_left = 0;
  endtask

  task automatic test_halt_backpressure;
    load(8'h00, 8'h00, 64'd0, -1);
    run_fetch(64'h1234, 5, "halt_bp");
  endtask

  task automatic test_invalid;
    load(8'hC0, 8'h00, 64'd0, -1);
    run_fetch(64'h500, 2, "invalid");
    load(8'h10, 8'h00, 64'd0, -1);
    run_fetch(64'h501, 0, "after_invalid");
  endtask

  task automatic test_reset_mid;
    int guard;
    load(8'h50, 8'h12, 64'h1122334455667788, 2);
    base   = 64'h300;
    stalls = 0;
    acked.delete();
    pc_valid = 1'b1;
    pc_in    = 64'h300;
    @(posedge clk);
    #1;
    pc_valid = 1'b0;
    guard = 0;
    while (acked.size() < 5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_req !== 1'b0 || pc_ready !== 1'b1 || out_valid !== 1'b0 || icode !== 4'h0 ||
        rA !== 4'hF || rB !== 4'hF || valC !== 64'd0 || valP !== 64'd0 ||
        mem_addr !== 64'd0 || instr_err !== 1'b0 || acked.size() < 5) begin
      bad++;
      $display("FAIL reset_mid: got req=%b pr=%b ic=%h valC=%h addr=%h n=%0d", mem_req,
               pc_ready, icode, valC, mem_addr, acked.size());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(8'h20, 8'h12, 64'd0, -1);
    run_fetch(64'h777, 0, "rrmov_after_reset");
  endtask

  task automatic test_random;
    logic [63:0] pc;
    rand_ack = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
      if (n % 4 == 0) pc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else            pc = {$urandom, $urandom};
      run_fetch(pc, $urandom_range(0, 3), $sformatf("rand%0d", n));
    end
    rand_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pc_valid  = 1'b0;
    pc_in     = 64'd0;
    out_ready = 1'b0;
    base      = 64'd0;
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_nop();
    test_irmov();
    test_call_stall();
    test_halt_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
